// File: rtl/toaster_fsm.sv
// toaster_fsm: toaster control FSM with button sync, second timer and registered outputs
// Ports: iCLK clock; iRST_N async active-low reset; iPOWER/iSTART/iEJECT async buttons;
//        oESTADO 3-bit state code for the LCD stage; oLCD_RST one-cycle pulse on state change;
//        oHEATER heater enable; oBUZZER alarm enable (only when TOASTER_BUZZER_EN is defined).
module toaster_fsm #(
  parameter int CLK_HZ    = 50000000,
  parameter int PREP_SECS = 10,
  parameter int BURN_SECS = 5,
  parameter int MSG_SECS  = 3
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iPOWER,
  input  logic       iSTART,
  input  logic       iEJECT,
  output logic [2:0] oESTADO,
  output logic       oLCD_RST,
  output logic       oHEATER,
  output logic       oBUZZER
);
  localparam logic [2:0] DESLIGADO = 3'd0, LIGADO = 3'd1, PREPARO = 3'd2,
                         PRONTO = 3'd3, QUEIMANDO = 3'd4, BOM_APETITE = 3'd5;
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_END = PW'(CLK_HZ - 1);
  localparam logic [7:0] PREP_END = 8'(PREP_SECS - 1);
  localparam logic [7:0] BURN_END = 8'(BURN_SECS - 1);
  localparam logic [7:0] MSG_END  = 8'(MSG_SECS - 1);
  logic [2:0] sync1, sync2, prev, press;
  logic [PW-1:0] presc;
  logic [7:0] secs;
  logic tick, stateChange, heaterNext;
  logic [2:0] nextState;
  assign press = sync2 & ~prev;
  assign tick = presc == PRESC_END;
  // A timeout fires in the last cycle of the Nth second, so the new code appears exactly N*CLK_HZ cycles after entry.
  always_comb begin
    nextState = oESTADO;
    if (press[0])
      nextState = (oESTADO == DESLIGADO) ? LIGADO : DESLIGADO;
    else
      case (oESTADO)
        LIGADO:      nextState = press[1] ? PREPARO : LIGADO;
        PREPARO:     nextState = (tick && secs == PREP_END) ? PRONTO : PREPARO;
        PRONTO:      nextState = press[2] ? BOM_APETITE : (tick && secs == BURN_END) ? QUEIMANDO : PRONTO;
        QUEIMANDO:   nextState = press[2] ? BOM_APETITE : QUEIMANDO;
        BOM_APETITE: nextState = (tick && secs == MSG_END) ? LIGADO : BOM_APETITE;
        default:     nextState = DESLIGADO;
      endcase
  end
  always_comb begin
    stateChange = nextState != oESTADO;
    heaterNext = nextState == PREPARO || nextState == PRONTO;
  end
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      sync1 <= '0;
      sync2 <= '0;
      prev <= '0;
      presc <= '0;
      secs <= '0;
      oESTADO <= DESLIGADO;
      oLCD_RST <= 1'b0;
      oHEATER <= 1'b0;
    end else begin
      sync1 <= {iEJECT, iSTART, iPOWER};
      sync2 <= sync1;
      prev <= sync2;
      presc <= (stateChange || tick) ? '0 : presc + PW'(1);
      secs <= stateChange ? '0 : secs + 8'(tick);
      oESTADO <= nextState;
      oLCD_RST <= stateChange;
      oHEATER <= heaterNext;
    end
`ifdef TOASTER_BUZZER_EN
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) oBUZZER <= 1'b0;
    else oBUZZER <= nextState == QUEIMANDO;
`else
  assign oBUZZER = 1'b0;
`endif
endmodule
